pc_branch_unit: RTL

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch PC sequencer with branch/jump redirect handling.
// Redirects that arrive while instruction memory is busy are parked in a
// pending register and applied on the next accepted fetch. Every applied
// redirect produces a one-cycle flush pulse and bumps a saturating counter.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch_valid,
  input  logic [3:0]              branch_ctl,
  input  logic signed [31:0]      branch_out,
  input  logic                    jump,
  input  logic [31:0]             target,
  input  logic                    stall,
  input  logic                    imem_ready,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  output logic [31:0]             pc,
  output logic                    flush,
  output logic                    misalign,
  output logic [CNT_W-1:0]        redirect_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PEND  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pend_q, pend_d;
  logic               flush_q, flush_d;
  logic               misalign_q, misalign_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cond_op;
  logic               taken;
  logic               apply_redirect;
  logic               req_c;
  logic [31:0]        target_aligned;

  // Only the four recognised compare opcodes can make a conditional branch taken.
  always_comb begin
    cond_op = (branch_ctl == 4'b0111) || (branch_ctl == 4'b1011) ||
              (branch_ctl == 4'b1100) || (branch_ctl == 4'b1101);
    taken          = branch_valid & (jump | (cond_op & (branch_out != 32'sd0)));
    target_aligned = {target[31:2], 2'b00};
  end

  // Next-state and fetch-request logic; a redirect beats stall, but waits for imem_ready.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_d         = pend_q;
    req_c          = 1'b0;
    apply_redirect = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req_c = 1'b1;
        if (taken) begin
          if (imem_ready) begin
            pc_d           = target_aligned;
            apply_redirect = 1'b1;
          end else begin
            pend_d  = target_aligned;
            state_d = ST_PEND;
          end
        end else if (imem_ready && !stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_PEND: begin
        req_c = 1'b1;
        if (imem_ready) begin
          // A redirect resolved in the same cycle is younger and wins.
          pc_d           = taken ? target_aligned : pend_q;
          apply_redirect = 1'b1;
          state_d        = ST_FETCH;
        end else if (taken) begin
          pend_d = target_aligned;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    flush_d    = apply_redirect;
    misalign_d = misalign_q | (taken & (target[1:0] != 2'b00));
    cnt_d      = (apply_redirect && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;
  end

  // State and datapath registers; reset discards any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 32'd0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req     = req_c;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign flush        = flush_q;
  assign misalign     = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule
